mp_add_seq: RTL

- Multi-precision add/subtract sequencer. Computes WORDS*N-bit operations by driving one external N-bit carry-lookahead adder once per cycle, least-significant word first, and rippling the carry through a register.
- Sits between a requester (valid/ready command and result handshakes) and a shared N-bit adder instance. It owns the adder's operand and carry inputs for the whole operation.

---
 rtl/mp_add_seq.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: drives one external N-bit adder
// once per cycle, least-significant word first, rippling the carry through
// a register to build a WORDS*N-bit sum or difference.
module mp_add_seq #(
    parameter int unsigned N     = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    // command handshake
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic                 op_sub,
    input  logic [N*WORDS-1:0]   a,
    input  logic [N*WORDS-1:0]   b,
    // shared adder
    output logic [N-1:0]         add_x,
    output logic [N-1:0]         add_y,
    output logic                 add_cin,
    input  logic [N-1:0]         add_sum,
    input  logic                 add_cout,
    input  logic                 add_ovf,
    // result handshake
    output logic                 done_valid,
    input  logic                 done_ready,
    output logic [N*WORDS-1:0]   result,
    output logic                 c_out,
    output logic                 overflow
);

    localparam int unsigned W    = N * WORDS;
    localparam int unsigned IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic              carry_q, carry_d;
    logic [W-1:0]      a_q,     a_d;
    logic [W-1:0]      b_q,     b_d;
    logic [W-1:0]      result_q, result_d;
    logic              c_out_q, c_out_d;
    logic              ovf_q,   ovf_d;
    logic              done_q,  done_d;

    logic [31:0]       base_c;
    logic              last_word_c;

    // Bit offset of the word currently being processed
    assign base_c      = 32'(idx_q) * 32'(N);
    assign last_word_c = (idx_q == IDXW'(WORDS - 1));

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            c_out_q  <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            c_out_q  <= c_out_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic: accept, ripple one word per cycle, hold result
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        c_out_d  = c_out_q;
        ovf_d    = ovf_q;
        done_d   = done_q;

        case (state_q)
            S_IDLE: begin
                if (start_valid) begin
                    // Subtraction is a + ~b + 1: invert B once, seed carry with 1
                    a_d      = a;
                    b_d      = op_sub ? ~b : b;
                    carry_d  = op_sub;
                    idx_d    = '0;
                    result_d = '0;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                result_d[base_c +: N] = add_sum;
                carry_d               = add_cout;
                if (last_word_c) begin
                    // Only the top word's overflow describes the full-width result
                    c_out_d = add_cout;
                    ovf_d   = add_ovf;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_DONE: begin
                if (done_ready) begin
                    done_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Adder drive: current operand word while running, zeros otherwise
    always_comb begin
        add_x   = '0;
        add_y   = '0;
        add_cin = 1'b0;
        if (state_q == S_RUN) begin
            add_x   = a_q[base_c +: N];
            add_y   = b_q[base_c +: N];
            add_cin = carry_q;
        end
    end

    assign start_ready = (state_q == S_IDLE);
    assign done_valid  = done_q;
    assign result      = result_q;
    assign c_out       = c_out_q;
    assign overflow    = ovf_q;

endmodule
